// File: rtl/voice_pkg.sv
// Shared constants for the voice scheduler: FSM encodings, config field codes
// and the fixed shifts applied to ROM data and to the final mix.
package voice_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t OUTPUT = 2'd3;

  localparam logic CFG_FREQ = 1'b0;
  localparam logic CFG_ENV  = 1'b1;

  localparam int ROM_SHIFT = 7;
  localparam int MIX_SHIFT = 16;

endpackage

// File: rtl/voice_regfile.sv
// Per-voice frequency, envelope and phase storage with one config write port,
// two combinational read ports and a strobe that advances every phase at once.
module voice_regfile
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 12,
  parameter int FREQ_W     = 16,
  parameter int ENV_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic                          wr_field,
  input  logic [FREQ_W-1:0]             wr_data,
  input  logic                          advance,
  input  logic [$clog2(NUM_VOICES)-1:0] phase_idx,
  output logic [PHASE_W-1:0]            phase_rd,
  input  logic [$clog2(NUM_VOICES)-1:0] env_idx,
  output logic [ENV_W-1:0]              env_rd
);

  // Only the low PHASE_W bits of a frequency word ever reach the phase sum.
  logic [PHASE_W-1:0] freq_reg  [NUM_VOICES];
  logic [ENV_W-1:0]   env_reg   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_reg [NUM_VOICES];
  logic [PHASE_W-1:0] phase_next [NUM_VOICES];
  logic               data_hi_unused;

  assign data_hi_unused = ^wr_data[FREQ_W-1:PHASE_W];

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_advance
    assign phase_next[gi] = phase_reg[gi] + freq_reg[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        freq_reg[k]  <= '0;
        env_reg[k]   <= '0;
        phase_reg[k] <= '0;
      end
    end else begin
      if (advance) begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          phase_reg[k] <= phase_next[k];
        end
      end
      if (wr_en && wr_field == CFG_FREQ) freq_reg[wr_voice] <= wr_data[PHASE_W-1:0];
      if (wr_en && wr_field == CFG_ENV)  env_reg[wr_voice]  <= wr_data[ENV_W-1:0];
    end
  end

  assign phase_rd = phase_reg[phase_idx];
  assign env_rd   = env_reg[env_idx];

endmodule

// File: rtl/voice_scheduler.sv
// Shares one wavetable ROM port across NUM_VOICES voices: each sample tick runs
// a frame that reads every voice, scales by its envelope and emits a saturated mix.
module voice_scheduler
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 12,
  parameter int FREQ_W     = 16,
  parameter int SAMPLE_W   = 32,
  parameter int ENV_W      = 8,
  parameter int OUT_W      = 8,
  parameter int TICK_DIV   = 501
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic                          cfg_field,
  input  logic [FREQ_W-1:0]             cfg_data,
  output logic [PHASE_W-1:0]            rom_addr,
  input  logic [SAMPLE_W-1:0]           rom_data,
  output logic [OUT_W-1:0]              mix_out,
  output logic                          mix_valid,
  output logic                          busy
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int PROD_W = SAMPLE_W - ROM_SHIFT + ENV_W;
  localparam int ACC_W  = PROD_W + IDX_W;

  if (TICK_DIV < NUM_VOICES + 3) begin : g_tick_check
    $error("TICK_DIV must be at least NUM_VOICES+3");
  end

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   tick_count_reg;
  logic [PHASE_W-1:0] rom_addr_reg;
  logic [OUT_W-1:0]   mix_out_reg;
  logic               mix_valid_reg;

  logic               wrap_cycle;
  logic               cfg_accept;
  logic [IDX_W-1:0]   env_idx;
  logic [PHASE_W-1:0] phase_rd;
  logic [ENV_W-1:0]   env_rd;
  logic [PROD_W-1:0]  product;
  logic [OUT_W-1:0]   mix_sat;
  logic               rom_low_unused;

  assign wrap_cycle = (tick_count_reg == CNT_W'(TICK_DIV - 1));
  assign cfg_ready  = !reset && (state_reg == IDLE) && !wrap_cycle;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign busy       = (state_reg != IDLE);

  // rom_data answers the address issued one cycle earlier, so the envelope
  // lags idx by one; in DRAIN idx has wrapped to 0 and this selects the last voice.
  assign env_idx = idx_reg - IDX_W'(1);

  assign rom_low_unused = ^rom_data[ROM_SHIFT-1:0];
  assign product = PROD_W'(rom_data[SAMPLE_W-1:ROM_SHIFT]) * PROD_W'(env_rd);
  assign mix_sat = (|acc_reg[ACC_W-1:MIX_SHIFT+OUT_W]) ? '1
                 : acc_reg[MIX_SHIFT+OUT_W-1:MIX_SHIFT];

  voice_regfile #(
    .NUM_VOICES(NUM_VOICES),
    .PHASE_W   (PHASE_W),
    .FREQ_W    (FREQ_W),
    .ENV_W     (ENV_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_accept),
    .wr_voice (cfg_voice),
    .wr_field (cfg_field),
    .wr_data  (cfg_data),
    .advance  (state_reg == OUTPUT),
    .phase_idx(idx_reg),
    .phase_rd (phase_rd),
    .env_idx  (env_idx),
    .env_rd   (env_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      acc_reg        <= '0;
      tick_count_reg <= '0;
      rom_addr_reg   <= '0;
      mix_out_reg    <= '0;
      mix_valid_reg  <= 1'b0;
    end else begin
      tick_count_reg <= wrap_cycle ? '0 : tick_count_reg + CNT_W'(1);
      mix_valid_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wrap_cycle) begin
            state_reg <= ISSUE;
            idx_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        ISSUE: begin
          rom_addr_reg <= phase_rd;
          if (idx_reg != '0) acc_reg <= acc_reg + ACC_W'(product);
          idx_reg <= idx_reg + IDX_W'(1);
          if (idx_reg == IDX_W'(NUM_VOICES - 1)) state_reg <= DRAIN;
        end
        DRAIN: begin
          acc_reg   <= acc_reg + ACC_W'(product);
          state_reg <= OUTPUT;
        end
        OUTPUT: begin
          mix_out_reg   <= mix_sat;
          mix_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign mix_out   = mix_out_reg;
  assign mix_valid = mix_valid_reg;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: stimulus queues the expected rom
// addresses and mix for each frame, a monitor checks them on every mix_valid.
module tb_voice_scheduler;

  localparam int NV = 8;
  localparam int TD = 16;

  typedef struct packed {
    logic [NV-1:0][11:0] addr;
    logic [7:0]          mix;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_voice = '0;
  logic        cfg_field = 1'b0;
  logic [15:0] cfg_data = '0;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  mix_out;
  logic        mix_valid;
  logic        busy;
  logic        rom_all_ones = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int n_frames = 0;
  frame_t exp_q[$];
  logic [11:0] m_phase [NV];
  logic [15:0] m_freq  [NV];

  always #5 clk = ~clk;

  // ROM model: rom_data = addr<<20, so each voice adds addr*env/8 to the mix.
  assign rom_data = rom_all_ones ? 32'hFFFF_FFFF : {rom_addr, 20'h0_0000};

  voice_scheduler #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice),
    .cfg_field(cfg_field),
    .cfg_data (cfg_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .mix_out  (mix_out),
    .mix_valid(mix_valid),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      m_phase[k] = '0;
      m_freq[k]  = '0;
    end
  endtask

  task automatic push_frame(input logic [7:0] mix);
    frame_t f;
    for (int k = 0; k < NV; k++) begin
      f.addr[k]  = m_phase[k];
      m_phase[k] = m_phase[k] + m_freq[k][11:0];
    end
    f.mix = mix;
    exp_q.push_back(f);
  endtask

  task automatic cfg_write(input int v, input logic f, input logic [15:0] d, output int stalls);
    bit done;
    bit rdy;
    done = 0;
    stalls = 0;
    cfg_valid = 1'b1;
    cfg_voice = v[2:0];
    cfg_field = f;
    cfg_data  = d;
    for (int t = 0; t < 40 && !done; t++) begin
      rdy = cfg_ready;
      @(negedge clk);
      if (rdy) done = 1;
      else stalls++;
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", 64'(done), 64'd1);
    if (f == 1'b0) m_freq[v] = d;
  endtask

  task automatic wr(input int v, input logic f, input logic [15:0] d);
    int s;
    cfg_write(v, f, d, s);
  endtask

  task automatic wait_mix();
    bit seen;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (mix_valid) seen = 1;
    end
    chk("mix_valid_timeout", 64'(seen), 64'd1);
  endtask

  int          mon_cnt = -1;
  logic        busy_q = 1'b0;
  logic [NV-1:0][11:0] cap;

  always @(negedge clk) begin
    frame_t e;
    if (reset) begin
      mon_cnt = -1;
      busy_q  = 1'b0;
    end else begin
      if (busy && !busy_q) mon_cnt = 0;
      else if (mon_cnt >= 0) mon_cnt++;
      if (mon_cnt >= 1 && mon_cnt <= NV) cap[mon_cnt-1] = rom_addr;
      if (mix_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mix_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          n_frames++;
          chk("frame_latency", 64'(mon_cnt), 64'(NV + 2));
          for (int k = 0; k < NV; k++) chk($sformatf("rom_addr_v%0d", k), 64'(cap[k]), 64'(e.addr[k]));
          chk("mix_out", 64'(mix_out), 64'(e.mix));
          $display("frame %0d: mix_out=%0d expected=%0d", n_frames, mix_out, e.mix);
        end
        mon_cnt = -1;
      end
      busy_q = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int first_busy;
    int first_mv;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mix_valid", 64'(mix_valid), 64'd0);
    chk("rst_mix_out", 64'(mix_out), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);

    // Startup: release at cycle 0, wrap at 15, busy at 16, mix_valid at 26
    reset = 1'b0;
    #1;
    chk("start_cfg_ready", 64'(cfg_ready), 64'd1);
    push_frame(8'd0);
    first_busy = -1;
    first_mv = -1;
    for (int c = 0; c < 40 && first_mv < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (busy && first_busy < 0) first_busy = c;
      if (mix_valid) first_mv = c;
    end
    chk("start_busy_cycle", 64'(first_busy), 64'd16);
    chk("start_mix_valid_cycle", 64'(first_mv), 64'd26);

    // Single voice 0: freq 0x100, env 3 -> addr*3/8
    wr(0, 1'b0, 16'h0100);
    wr(0, 1'b1, 16'd3);
    push_frame(8'd0);
    wait_mix();
    wr(3, 1'b0, 16'h0FFF);
    push_frame(8'd96);
    wait_mix();
    push_frame(8'd192);
    wait_mix();
    // 0x300*3/8 = 288 saturates; freq 0x1005 acts as 0x005
    wr(3, 1'b0, 16'h1005);
    push_frame(8'd255);
    wait_mix();
    // env0=0 silences voice 0; voice 3 at phase 3 with env 200 -> 75
    wr(0, 1'b1, 16'd0);
    wr(3, 1'b1, 16'd200);
    push_frame(8'd75);
    wait_mix();

    // Saturation with an all-ones ROM
    rom_all_ones = 1'b1;
    wr(0, 1'b1, 16'd255);
    wr(1, 1'b1, 16'd255);
    wr(2, 1'b1, 16'd255);
    push_frame(8'd255);
    wait_mix();

    rom_all_ones = 1'b0;
    wr(0, 1'b1, 16'd0);
    wr(3, 1'b1, 16'd8);
    push_frame(8'd13);
    wait_mix();

    // Config collision: request raised on the wrap cycle stalls through OUTPUT
    push_frame(8'd18);
    repeat (5) @(negedge clk);
    chk("wrap_cfg_ready", 64'(cfg_ready), 64'd0);
    cfg_write(3, 1'b1, 16'd16, st);
    chk("collision_stalls", 64'(st), 64'd11);
    push_frame(8'd46);
    wait_mix();

    // Reset during ISSUE idx=4 aborts the frame
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("midrst_mix_out", 64'(mix_out), 64'd0);
    chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_mix_valid", 64'(mix_valid), 64'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_mix_out", 64'(mix_out), 64'd0);
    wr(0, 1'b0, 16'h0040);
    wr(0, 1'b1, 16'd5);
    push_frame(8'd0);
    wait_mix();
    push_frame(8'd40);
    wait_mix();

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
